// File: rtl/float_accumulator_single.sv
// Streams a counted run of floats through an external single-precision adder, keeping a running sum and sticky flags.
// Result valid the cycle after the last accepted operand; one operand per cycle, input stalls on in_valid, result held until res_ready.
module float_accumulator_single #(
  parameter int FLOAT_SIZE    = 32,
  parameter int EXPONENT_SIZE = 8,
  parameter int MANTISSA_SIZE = 23,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FLOAT_SIZE-1:0]  in_data,
  output logic [FLOAT_SIZE-1:0]  add_a,
  output logic [FLOAT_SIZE-1:0]  add_b,
  input  logic [FLOAT_SIZE-1:0]  add_out,
  input  logic                   add_overflow,
  input  logic                   add_underflow,
  input  logic                   add_inexact,
  input  logic                   add_zero,
  output logic                   busy,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [FLOAT_SIZE-1:0]  res_data,
  output logic                   res_overflow,
  output logic                   res_underflow,
  output logic                   res_inexact,
  output logic                   res_zero
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRST = 2'd1,
    S_ACCUM = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state;
  state_t                 state_nxt;
  logic [FLOAT_SIZE-1:0]  acc;
  logic [COUNT_WIDTH-1:0] remaining;
  logic                   sticky_ovf;
  logic                   sticky_unf;
  logic                   sticky_inx;
  logic                   zero_q;
  logic                   accept;
  logic                   last_beat;

  assign accept    = in_valid & in_ready;
  assign last_beat = (remaining == CNT_ONE);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (len == CNT_ZERO) ? S_DONE : S_FIRST;
      end
      S_FIRST: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = last_beat ? S_DONE : S_ACCUM;
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last_beat) state_nxt = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      acc        <= '0;
      remaining  <= '0;
      sticky_ovf <= 1'b0;
      sticky_unf <= 1'b0;
      sticky_inx <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            sticky_ovf <= 1'b0;
            sticky_unf <= 1'b0;
            sticky_inx <= 1'b0;
            if (len == CNT_ZERO) begin
              acc    <= '0;
              zero_q <= 1'b1;
            end else begin
              remaining <= len;
            end
          end
        end
        S_FIRST: begin
          // First operand is loaded directly so the sum never sees a seed of +0.
          if (accept) begin
            acc       <= in_data;
            zero_q    <= (in_data[EXPONENT_SIZE+MANTISSA_SIZE-1:0] == '0);
            remaining <= remaining - CNT_ONE;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            acc        <= add_out;
            zero_q     <= add_zero;
            sticky_ovf <= sticky_ovf | add_overflow;
            sticky_unf <= sticky_unf | add_underflow;
            sticky_inx <= sticky_inx | add_inexact;
            remaining  <= remaining - CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = (state != S_IDLE);
  assign add_a         = acc;
  assign add_b         = in_data;
  assign res_data      = acc;
  assign res_overflow  = sticky_ovf;
  assign res_underflow = sticky_unf;
  assign res_inexact   = sticky_inx;
  assign res_zero      = zero_q;

endmodule

// File: tb/tb_float_accumulator_single.sv
// Directed bench for float_accumulator_single with a table-driven stand-in for the float adder.
module tb_float_accumulator_single;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_out;
  logic        add_overflow;
  logic        add_underflow;
  logic        add_inexact;
  logic        add_zero;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_overflow;
  logic        res_underflow;
  logic        res_inexact;
  logic        res_zero;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  float_accumulator_single #(
    .FLOAT_SIZE(32), .EXPONENT_SIZE(8), .MANTISSA_SIZE(23), .COUNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .add_a(add_a), .add_b(add_b), .add_out(add_out),
    .add_overflow(add_overflow), .add_underflow(add_underflow),
    .add_inexact(add_inexact), .add_zero(add_zero),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_overflow(res_overflow), .res_underflow(res_underflow),
    .res_inexact(res_inexact), .res_zero(res_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder stand-in: only the operand pairs the bench expects are known; anything else returns a marker.
  always_comb begin
    add_out       = 32'hDEADBEEF;
    add_overflow  = 1'b0;
    add_underflow = 1'b0;
    add_inexact   = 1'b0;
    add_zero      = 1'b0;
    case ({add_a, add_b})
      {32'h3F800000, 32'h40000000}: add_out = 32'h40400000;
      {32'h40400000, 32'h3FC00000}: add_out = 32'h40900000;
      {32'h3FC00000, 32'hBFC00000}: begin add_out = 32'h00000000; add_zero = 1'b1; end
      {32'h3F800000, 32'h30C00000}: begin add_out = 32'h3F800000; add_inexact = 1'b1; end
      {32'h40000000, 32'h40000000}: add_out = 32'h40800000;
      {32'h7F7FFFFF, 32'h7F7FFFFF}: begin add_out = 32'h7F800000; add_overflow = 1'b1; add_inexact = 1'b1; end
      {32'h7F800000, 32'h3F800000}: add_out = 32'h7F800000;
      {32'h00800001, 32'h80800000}: begin add_out = 32'h00000001; add_underflow = 1'b1; end
      {32'h00000001, 32'h3F800000}: begin add_out = 32'h3F800000; add_inexact = 1'b1; end
      {32'h00000000, 32'h00000000}: begin add_out = 32'h00000000; add_zero = 1'b1; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    step();
    start = 1'b0;
  endtask

  // Present one operand and hold it until it is accepted (bounded).
  task automatic feed(input logic [31:0] op);
    in_valid = 1'b1;
    in_data  = op;
    for (int n = 0; n < 20; n++) begin
      if (in_ready) break;
      step();
    end
    check_bit("in_ready_wait", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [31:0] data,
                              input logic ovf, input logic unf, input logic inx, input logic zero);
    check_bit({tag, "_valid"}, res_valid, 1'b1);
    check({tag, "_data"}, res_data, data);
    check_bit({tag, "_ovf"}, res_overflow, ovf);
    check_bit({tag, "_unf"}, res_underflow, unf);
    check_bit({tag, "_inx"}, res_inexact, inx);
    check_bit({tag, "_zero"}, res_zero, zero);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check_bit("idle_after_consume", busy, 1'b0);
  endtask

  initial begin
    int accepts;
    rst_n = 1'b0; start = 1'b0; len = 8'd0;
    in_valid = 1'b0; in_data = 32'h0; res_ready = 1'b0;
    step(); step();
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_in_ready", in_ready, 1'b0);
    check_bit("rst_res_valid", res_valid, 1'b0);
    check("rst_res_data", res_data, 32'h0);
    check_bit("rst_res_zero", res_zero, 1'b0);
    rst_n = 1'b1;
    step();

    // 1 + 2 + 1.5 = 4.5, result visible the cycle after the third accept
    start_run(8'd3);
    check_bit("t1_busy", busy, 1'b1);
    feed(32'h3F800000);
    feed(32'h40000000);
    feed(32'h3FC00000);
    check_bit("t1_in_ready_done", in_ready, 1'b0);
    check_result("t1", 32'h40900000, 1'b0, 1'b0, 1'b0, 1'b0);
    consume();

    // 1.5 + -1.5 cancels exactly
    start_run(8'd2);
    feed(32'h3FC00000);
    feed(32'hBFC00000);
    check_result("t2", 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1);
    consume();

    // tiny addend is rounded away
    start_run(8'd2);
    feed(32'h3F800000);
    feed(32'h30C00000);
    check_result("t3", 32'h3F800000, 1'b0, 1'b0, 1'b1, 1'b0);
    consume();

    // empty run: immediate zero result, no operand taken
    start_run(8'd0);
    check_bit("t4_in_ready", in_ready, 1'b0);
    check_result("t4", 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1);
    consume();

    // input gaps, ignored start pulses, result backpressure
    start_run(8'd2);
    for (int i = 0; i < 3; i++) step();
    check_bit("t5_wait_in_ready", in_ready, 1'b1);
    feed(32'h40000000);
    start = 1'b1; len = 8'd0;
    for (int i = 0; i < 3; i++) step();
    start = 1'b0;
    check_bit("t5_busy_gap", busy, 1'b1);
    feed(32'h40000000);
    start = 1'b1; len = 8'd1;
    for (int i = 0; i < 5; i++) begin
      check_bit("t5_hold_in_ready", in_ready, 1'b0);
      check("t5_hold_data", res_data, 32'h40800000);
      step();
    end
    start = 1'b0;
    check_result("t5", 32'h40800000, 1'b0, 1'b0, 1'b0, 1'b0);
    consume();
    check_bit("t5_no_restart", busy, 1'b0);

    // overflow is sticky while accumulation continues
    start_run(8'd3);
    feed(32'h7F7FFFFF);
    feed(32'h7F7FFFFF);
    feed(32'h3F800000);
    check_result("ovf", 32'h7F800000, 1'b1, 1'b0, 1'b1, 1'b0);
    consume();

    // underflow is sticky through a later normal add
    start_run(8'd3);
    feed(32'h00800001);
    feed(32'h80800000);
    feed(32'h3F800000);
    check_result("unf", 32'h3F800000, 1'b0, 1'b1, 1'b1, 1'b0);
    consume();

    // single negative zero operand passes through unchanged
    start_run(8'd1);
    feed(32'h80000000);
    check_result("negzero", 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b1);
    consume();

    // maximum length, continuous stream, exact beat count
    start_run(8'd255);
    in_valid = 1'b1;
    in_data  = 32'h0;
    accepts  = 0;
    for (int n = 0; n < 400; n++) begin
      if (res_valid) break;
      if (in_ready) accepts++;
      step();
    end
    in_valid = 1'b0;
    check("max_accepts", accepts, 32'd255);
    check_result("max", 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1);
    consume();

    // reset mid-run aborts with no result
    start_run(8'd3);
    feed(32'h40000000);
    #2 rst_n = 1'b0;
    #1;
    check_bit("abort_busy", busy, 1'b0);
    check_bit("abort_in_ready", in_ready, 1'b0);
    check_bit("abort_res_valid", res_valid, 1'b0);
    check("abort_res_data", res_data, 32'h0);
    check_bit("abort_res_zero", res_zero, 1'b0);
    step(); step();
    rst_n = 1'b1;
    step(); step();
    check_bit("abort_still_idle", res_valid, 1'b0);
    start_run(8'd1);
    feed(32'h40490FDB);
    check_result("after_abort", 32'h40490FDB, 1'b0, 1'b0, 1'b0, 1'b0);
    consume();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
